// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg
//   Shared definitions for the frame-synchronous game controller:
//   state encoding, square colours, frame-end counter values, button
//   indices and the screen geometry used by the collision test.
//   Geometry constants are 11 bits wide so that box bounds computed from
//   10-bit offsets never wrap.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int PTR_W = 10;

  // Square colours as consumed by the VGA colour input
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

  // Last pixel of the last line: one tick per frame
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd520;

  // Button bit positions in the sampled/pending vectors
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_START = 2;

  // Screen geometry (inclusive boxes)
  localparam logic [10:0] PLAYER_X0 = 11'd240;
  localparam logic [10:0] PLAYER_W  = 11'd96;
  localparam logic [10:0] PLAYER_Y0 = 11'd333;
  localparam logic [10:0] PLAYER_Y1 = 11'd460;
  localparam logic [10:0] OBJ1_X0   = 11'd272;
  localparam logic [10:0] OBJ2_X0   = 11'd368;
  localparam logic [10:0] OBJ_W     = 11'd32;
  localparam logic [10:0] OBJ_Y0    = 11'd77;
  localparam logic [10:0] OBJ_H     = 11'd32;

  // Object 2 starts part-way down so the two objects are staggered
  localparam int FALL2_INIT = 96;

  // HIT colour flips every 8 frames
  localparam int HIT_TOGGLE_BIT = 3;

  // Inclusive interval overlap
  function automatic logic overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                   input logic [10:0] b_lo, input logic [10:0] b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

endpackage

// File: rtl/game_sequencer_fall_timer.sv
// fall_timer
//   Per-object frame counter and falling pointer. On every enabled tick the
//   counter advances; on the PERIOD-th tick it wraps and the pointer steps
//   down by STEP, returning to 0 once it would pass LIMIT.
// Ports
//   Clock   : pixel clock
//   Reset   : synchronous active-high reset (pointer <= INIT, counter <= 0)
//   Enable  : allow the counter to advance on this tick
//   Tick    : end-of-frame strobe, the only cycle state changes
//   Restart : on a tick, reload the reset values (takes priority over Enable)
//   Pointer : current pointer value
module fall_timer
  import game_sequencer_pkg::*;
#(
  parameter int PERIOD = 45,
  parameter int STEP   = 32,
  parameter int LIMIT  = 384,
  parameter int INIT   = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Tick,
  input  logic             Restart,
  output logic [PTR_W-1:0] Pointer
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [PTR_W-1:0] pointer_q, pointer_d;
  logic [PTR_W:0]   stepped;

  always_comb begin
    count_d   = count_q;
    pointer_d = pointer_q;
    // One extra bit so the limit compare cannot be fooled by wrap-around
    stepped   = {1'b0, pointer_q} + (PTR_W+1)'(STEP);
    if (Tick) begin
      if (Restart) begin
        count_d   = '0;
        pointer_d = PTR_W'(INIT);
      end else if (Enable) begin
        if (count_q == CW'(PERIOD - 1)) begin
          count_d   = '0;
          pointer_d = (stepped > (PTR_W+1)'(LIMIT)) ? '0 : stepped[PTR_W-1:0];
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q   <= '0;
      pointer_q <= PTR_W'(INIT);
    end else begin
      count_q   <= count_d;
      pointer_q <= pointer_d;
    end
  end

  assign Pointer = pointer_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
//   Frame-synchronous game controller. Turns button presses and per-object
//   frame timers into the player offset, falling-object pointers and square
//   colour for the VGA datapath, and runs the IDLE/RUN/HIT/OVER machine.
//   Everything except the button edge latches changes only on the frame
//   tick (last pixel of the last line), so a frame is never drawn with
//   mixed values.
// Ports
//   Clock, Reset            : pixel clock, synchronous active-high reset
//   iHcounter, iVcounter    : raster position from the VGA controller
//   iBtnLeft/Right/Start    : debounced, synchronized button levels
//   oXRedCounter            : player X offset
//   oYRedCounter            : player Y offset (always 0)
//   oFall1, oFall2          : falling-object pointers
//   oColorCuadro            : square colour
//   oGameOver               : high while in OVER
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int XSTART       = 128,
  parameter int XMAX         = 320,
  parameter int STEP         = 32,
  parameter int FALL1_FRAMES = 45,
  parameter int FALL2_FRAMES = 40,
  parameter int FALL_LIMIT   = 384,
  parameter int HIT_FRAMES   = 60
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [9:0]       iHcounter,
  input  logic [9:0]       iVcounter,
  input  logic             iBtnLeft,
  input  logic             iBtnRight,
  input  logic             iBtnStart,
  output logic [PTR_W-1:0] oXRedCounter,
  output logic [PTR_W-1:0] oYRedCounter,
  output logic [PTR_W-1:0] oFall1,
  output logic [PTR_W-1:0] oFall2,
  output logic [2:0]       oColorCuadro,
  output logic             oGameOver
);

  // At least 4 bits so the colour toggle bit always exists
  localparam int HW = (HIT_FRAMES > 16) ? $clog2(HIT_FRAMES) : 4;
  localparam logic [HW-1:0]    HIT_LAST = HW'(HIT_FRAMES - 1);
  localparam logic [PTR_W-1:0] STEP_W   = PTR_W'(STEP);
  localparam logic [PTR_W-1:0] XSTART_W = PTR_W'(XSTART);
  localparam logic [PTR_W:0]   XMAX_W   = (PTR_W+1)'(XMAX);

  logic tick;
  assign tick = (iHcounter == H_LAST) && (iVcounter == V_LAST);

  // ---------------- button edge capture ----------------
  logic [2:0] btn_q, btn_d;
  logic [2:0] btn_prev_q, btn_prev_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] btn_edge;

  always_comb begin
    btn_d    = {iBtnStart, iBtnRight, iBtnLeft};
    btn_edge = btn_q & ~btn_prev_q;
    // The previous-sample register holds on the tick so an edge that
    // coincides with the flag clear is seen again on the next cycle.
    btn_prev_d = tick ? btn_prev_q : btn_q;
    pend_d     = tick ? 3'b000 : (pend_q | btn_edge);
  end

  // ---------------- game state ----------------
  state_e           state_q, state_d;
  logic [PTR_W-1:0] x_q, x_d;
  logic [HW-1:0]    hit_cnt_q, hit_cnt_d;
  logic [2:0]       color_q, color_d;
  logic             over_q, over_d;

  logic [PTR_W-1:0] fall1, fall2;
  logic             fall_en, restart;

  // ---------------- collision (11-bit, no wrap) ----------------
  logic [10:0] px_lo, px_hi, o1_lo, o1_hi, o2_lo, o2_hi;
  logic        collision;

  always_comb begin
    px_lo = PLAYER_X0 + {1'b0, x_q};
    px_hi = px_lo + PLAYER_W - 11'd1;
    o1_lo = OBJ_Y0 + {1'b0, fall1};
    o1_hi = o1_lo + OBJ_H - 11'd1;
    o2_lo = OBJ_Y0 + {1'b0, fall2};
    o2_hi = o2_lo + OBJ_H - 11'd1;
    collision =
      (overlap(px_lo, px_hi, OBJ1_X0, OBJ1_X0 + OBJ_W - 11'd1) &&
       overlap(PLAYER_Y0, PLAYER_Y1, o1_lo, o1_hi)) ||
      (overlap(px_lo, px_hi, OBJ2_X0, OBJ2_X0 + OBJ_W - 11'd1) &&
       overlap(PLAYER_Y0, PLAYER_Y1, o2_lo, o2_hi));
  end

  // Objects only fall on RUN ticks that do not end in a collision
  assign fall_en = (state_q == ST_RUN) && !collision;
  assign restart = (state_q == ST_OVER) && pend_q[BTN_START];

  fall_timer #(
    .PERIOD (FALL1_FRAMES),
    .STEP   (STEP),
    .LIMIT  (FALL_LIMIT),
    .INIT   (0)
  ) u_fall1 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (fall_en),
    .Tick    (tick),
    .Restart (restart),
    .Pointer (fall1)
  );

  fall_timer #(
    .PERIOD (FALL2_FRAMES),
    .STEP   (STEP),
    .LIMIT  (FALL_LIMIT),
    .INIT   (FALL2_INIT)
  ) u_fall2 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (fall_en),
    .Tick    (tick),
    .Restart (restart),
    .Pointer (fall2)
  );

  // ---------------- state register ----------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_q      <= '0;
      btn_prev_q <= '0;
      pend_q     <= '0;
      state_q    <= ST_IDLE;
      x_q        <= XSTART_W;
      hit_cnt_q  <= '0;
      color_q    <= BLUE;
      over_q     <= 1'b0;
    end else begin
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      x_q        <= x_d;
      hit_cnt_q  <= hit_cnt_d;
      if (tick) begin
        color_q <= color_d;
        over_q  <= over_d;
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    hit_cnt_d = hit_cnt_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q[BTN_START]) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Collision is judged on the frame just shown; a hit freezes
          // the scene exactly as the player saw it.
          if (collision) begin
            state_d   = ST_HIT;
            hit_cnt_d = '0;
          end else if (pend_q[BTN_LEFT] && !pend_q[BTN_RIGHT]) begin
            if (x_q >= STEP_W) x_d = x_q - STEP_W;
          end else if (pend_q[BTN_RIGHT] && !pend_q[BTN_LEFT]) begin
            if (({1'b0, x_q} + {1'b0, STEP_W}) <= XMAX_W) x_d = x_q + STEP_W;
          end
        end
        ST_HIT: begin
          if (hit_cnt_q == HIT_LAST) state_d = ST_OVER;
          else hit_cnt_d = hit_cnt_q + HW'(1);
        end
        ST_OVER: begin
          if (pend_q[BTN_START]) begin
            state_d   = ST_IDLE;
            x_d       = XSTART_W;
            hit_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- output logic ----------------
  // Computed from the next state so the registered outputs describe the
  // state the coming frame is drawn in.
  always_comb begin
    color_d = BLUE;
    case (state_d)
      ST_IDLE: color_d = BLUE;
      ST_RUN:  color_d = GREEN;
      ST_HIT:  color_d = hit_cnt_d[HIT_TOGGLE_BIT] ? BLUE : RED;
      ST_OVER: color_d = RED;
      default: color_d = BLUE;
    endcase
    over_d = (state_d == ST_OVER);
  end

  assign oXRedCounter = x_q;
  assign oYRedCounter = '0;
  assign oFall1       = fall1;
  assign oFall2       = fall2;
  assign oColorCuadro = color_q;
  assign oGameOver    = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Drives the raster counters directly so that a "frame" is only a few
//   cycles long: a handful of cycles at an arbitrary position followed by
//   one cycle at H=799,V=520. Each frame (and each reset cycle) queues the
//   values expected after it; a separate monitor pops one entry on the
//   cycle after every tick or reset and compares all outputs.
module tb_game_sequencer;

  localparam int C_RED   = 4;
  localparam int C_GREEN = 2;
  localparam int C_BLUE  = 1;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [9:0] iHcounter, iVcounter;
  logic       iBtnLeft, iBtnRight, iBtnStart;
  logic [9:0] oXRedCounter, oYRedCounter, oFall1, oFall2;
  logic [2:0] oColorCuadro;
  logic       oGameOver;

  game_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iHcounter    (iHcounter),
    .iVcounter    (iVcounter),
    .iBtnLeft     (iBtnLeft),
    .iBtnRight    (iBtnRight),
    .iBtnStart    (iBtnStart),
    .oXRedCounter (oXRedCounter),
    .oYRedCounter (oYRedCounter),
    .oFall1       (oFall1),
    .oFall2       (oFall2),
    .oColorCuadro (oColorCuadro),
    .oGameOver    (oGameOver)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int id;
    int x;
    int f1;
    int f2;
    int col;
    int ov;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;
  bit   tick_prev = 1'b0;
  bit   rst_prev  = 1'b0;

  // Pointer positions 0,32,...,384 form a 13-entry ring
  function automatic int f1_at(input int n);
    return 32 * ((n / 45) % 13);
  endfunction

  function automatic int f2_at(input int n);
    return 32 * ((3 + n / 40) % 13);
  endfunction

  task automatic chk(input string what, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", what, id, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge Clock) begin
    tick_prev <= (iHcounter == 10'd799) && (iVcounter == 10'd520);
    rst_prev  <= Reset;
  end

  always @(negedge Clock) begin
    if (tick_prev || rst_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update t=%0t no queued expectation", $time);
      end else begin
        mon_e = exp_q.pop_front();
        $display("vec %0d: x=%0d y=%0d f1=%0d f2=%0d col=%0d over=%0d", mon_e.id,
                 oXRedCounter, oYRedCounter, oFall1, oFall2, oColorCuadro, oGameOver);
        chk("x",     mon_e.id, int'(oXRedCounter), mon_e.x);
        chk("y",     mon_e.id, int'(oYRedCounter), 0);
        chk("fall1", mon_e.id, int'(oFall1),       mon_e.f1);
        chk("fall2", mon_e.id, int'(oFall2),       mon_e.f2);
        chk("color", mon_e.id, int'(oColorCuadro), mon_e.col);
        chk("over",  mon_e.id, int'(oGameOver),    mon_e.ov);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int x, input int f1, input int f2, input int col, input int ov);
    exp_t e;
    vec_id++;
    e.id  = vec_id;
    e.x   = x;
    e.f1  = f1;
    e.f2  = f2;
    e.col = col;
    e.ov  = ov;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input int which);
    if (which == 0) iBtnLeft = 1'b1;
    else if (which == 1) iBtnRight = 1'b1;
    else iBtnStart = 1'b1;
    cyc();
    iBtnLeft  = 1'b0;
    iBtnRight = 1'b0;
    iBtnStart = 1'b0;
    cyc();
  endtask

  task automatic frame(input int nl, input int nr, input int ns,
                       input int x, input int f1, input int f2, input int col, input int ov);
    iHcounter = 10'd100;
    iVcounter = 10'd10;
    for (int i = 0; i < nl; i++) pulse(0);
    for (int i = 0; i < nr; i++) pulse(1);
    for (int i = 0; i < ns; i++) pulse(2);
    cyc();
    cyc();
    iHcounter = 10'd799;
    iVcounter = 10'd520;
    push(x, f1, f2, col, ov);
    cyc();
    iHcounter = 10'd0;
    iVcounter = 10'd0;
  endtask

  // Start's registered edge lands exactly on the tick cycle: the flag
  // clear wins, the request must survive into the following frame.
  task automatic start_on_tick(input int x, input int f1, input int f2, input int col, input int ov);
    iHcounter = 10'd100;
    iVcounter = 10'd10;
    cyc();
    iBtnStart = 1'b1;
    cyc();
    iHcounter = 10'd799;
    iVcounter = 10'd520;
    push(x, f1, f2, col, ov);
    cyc();
    iHcounter = 10'd0;
    iVcounter = 10'd0;
    cyc();
    iBtnStart = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    Reset     = 1'b1;
    iHcounter = 10'd0;
    iVcounter = 10'd0;
    iBtnLeft  = 1'b0;
    iBtnRight = 1'b0;
    iBtnStart = 1'b0;
    push(128, 0, 96, C_BLUE, 0);
    cyc();
    Reset = 1'b0;

    // Idle frames hold reset values
    repeat (3) frame(0, 0, 0, 128, 0, 96, C_BLUE, 0);

    // Deferred start, then RUN
    start_on_tick(128, 0, 96, C_BLUE, 0);
    frame(0, 0, 0, 128, 0, 96, C_GREEN, 0);

    // n counts RUN ticks without collision
    frame(0, 3, 0, 160, 0, 96, C_GREEN, 0);            // n=1, one move only
    frame(1, 1, 0, 160, 0, 96, C_GREEN, 0);            // n=2, both -> no move
    for (int k = 1; k <= 5; k++)                       // n=3..7
      frame(0, 1, 0, 160 + 32 * k, 0, 96, C_GREEN, 0);
    frame(0, 1, 0, 320, 0, 96, C_GREEN, 0);            // n=8, right edge
    for (int k = 1; k <= 10; k++)                      // n=9..18
      frame(1, 0, 0, 320 - 32 * k, 0, 96, C_GREEN, 0);
    frame(1, 0, 0, 0, 0, 96, C_GREEN, 0);              // n=19, left edge
    for (int k = 1; k <= 5; k++)                       // n=20..24
      frame(0, 1, 0, 32 * k, 0, 96, C_GREEN, 0);

    // X=160 clears both objects; drift through a wrap of object 1, then
    // walk left to X=32 under object 1 and wait for it to reach 256.
    for (int n = 25; n <= 945; n++) begin
      if (n <= 590) x = 160;
      else if (n <= 594) x = 160 - 32 * (n - 590);
      else x = 32;
      frame((n >= 591 && n <= 594) ? 1 : 0, 0, 0, x, f1_at(n), f2_at(n), C_GREEN, 0);
    end

    // Collision: frozen scene, RED x8 / BLUE x8 ..., OVER after 60 ticks
    frame(0, 0, 0, 32, 256, 0, C_RED, 0);
    for (int j = 1; j <= 59; j++)
      frame(0, 0, 0, 32, 256, 0, ((j / 8) % 2 == 0) ? C_RED : C_BLUE, 0);
    frame(0, 0, 0, 32, 256, 0, C_RED, 1);
    frame(1, 0, 0, 32, 256, 0, C_RED, 1);
    frame(0, 0, 1, 128, 0, 96, C_BLUE, 0);
    frame(0, 1, 0, 128, 0, 96, C_BLUE, 0);
    frame(0, 0, 1, 128, 0, 96, C_GREEN, 0);

    // Counters restarted: object 2 reaches the player at X=128 after 200 ticks
    for (int n = 1; n <= 200; n++)
      frame(0, 0, 0, 128, f1_at(n), f2_at(n), C_GREEN, 0);
    frame(0, 0, 0, 128, 128, 256, C_RED, 0);
    repeat (3) frame(0, 0, 0, 128, 128, 256, C_RED, 0);

    // Reset mid-HIT, mid-frame
    iHcounter = 10'd300;
    iVcounter = 10'd100;
    Reset     = 1'b1;
    push(128, 0, 96, C_BLUE, 0);
    cyc();
    Reset = 1'b0;
    frame(0, 0, 0, 128, 0, 96, C_BLUE, 0);
    frame(0, 0, 1, 128, 0, 96, C_GREEN, 0);
    frame(0, 1, 0, 160, 0, 96, C_GREEN, 0);

    cyc();
    cyc();
    chk("queue_drained", 0, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
